// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D SPI responder: frame geometry, FSM states,
// and the sample-to-response-word formatter.
package a2d_pkg;

  localparam int CMD_W    = 16;
  localparam int CHNL_MSB = 13;
  localparam int CHNL_LSB = 11;
  localparam int CHNL_W   = CHNL_MSB - CHNL_LSB + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Zero-extend a w-bit sample carried in the low bits of a command-width word.
  function automatic logic [CMD_W-1:0] resp_word(input logic [CMD_W-1:0] sample, input int w);
    logic [CMD_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < CMD_W; i++)
      if (i < w) mask[i] = 1'b1;
    return sample & mask;
  endfunction

endpackage

// File: rtl/a2d_spi_resp_sync_edge.sv
// Metastability synchronizer plus one history flop; rise/fall are single-clk
// pulses aligned with the synchronized level q.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      hist <= q;
    end
  end

  assign q    = sync[SYNC_STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder modelling an 8-channel A2D: captures a 16-bit command per frame
// and returns the sample of the channel latched by the previous complete frame.
module a2d_spi_resp
  import a2d_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SS_n,
  input  logic                     SCLK,
  input  logic                     MOSI,
  output logic                     MISO,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [CMD_W-1:0]         cmd,
  output logic [CHNL_W-1:0]        chnl,
  output logic                     cmd_rdy,
  output logic                     frame_err
);

  logic ss_lvl_unused, ss_rise, ss_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .rst(rst), .din(SS_n), .q(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst(rst), .din(SCLK), .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .rst(rst), .din(MOSI), .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  logic [DATA_W-1:0] ch_arr [NUM_CH];
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
  end

  state_t              state, state_nxt;
  logic [4:0]          bit_cnt, bit_cnt_nxt;
  logic [CMD_W-1:0]    tx_shft, tx_nxt, rx_shft, rx_nxt, cmd_nxt;
  logic [CHNL_W-1:0]   chnl_nxt;
  logic                rdy_nxt, err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      tx_shft   <= '0;
      rx_shft   <= '0;
      cmd       <= '0;
      chnl      <= '0;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      tx_shft   <= tx_nxt;
      rx_shft   <= rx_nxt;
      cmd       <= cmd_nxt;
      chnl      <= chnl_nxt;
      cmd_rdy   <= rdy_nxt;
      frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = tx_shft;
    rx_nxt      = rx_shft;
    cmd_nxt     = cmd;
    chnl_nxt    = chnl;
    rdy_nxt     = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        // Snapshot the sample now so mid-frame ch_data changes cannot leak in.
        if (ss_fall) begin
          tx_nxt      = resp_word(CMD_W'(ch_arr[chnl]), DATA_W);
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // SS_rise wins; any SCLK edge seen in the same clk is dropped.
        if (ss_rise) begin
          state_nxt = IDLE;
          if (bit_cnt == 5'd16) begin
            cmd_nxt  = rx_shft;
            chnl_nxt = rx_shft[CHNL_MSB:CHNL_LSB];
            rdy_nxt  = 1'b1;
          end else begin
            err_nxt  = 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            rx_nxt = {rx_shft[CMD_W-2:0], mosi_q};
            if (bit_cnt != 5'd31) bit_cnt_nxt = bit_cnt + 5'd1;
          end
          // The first fall is the front porch; MSB is already on MISO.
          if (sclk_fall && bit_cnt != 5'd0 && bit_cnt < 5'd16)
            tx_nxt = tx_shft << 1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign MISO = (state == SHIFT) & tx_shft[CMD_W-1];

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: a master drives frames, a frame-level model
// predicts responses and the per-clock values of cmd/chnl/cmd_rdy/frame_err.
module tb_a2d_spi_resp;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 12;
  localparam int SYNC   = 2;
  localparam int PH     = SYNC + 2;

  logic        clk = 1'b0;
  logic        rst, SS_n, SCLK, MOSI, MISO, cmd_rdy, frame_err;
  logic [15:0] cmd;
  logic [2:0]  chnl;
  logic [DATA_W-1:0]        ch_arr [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] ch_data;

  int cyc = 0, n_cmp = 0, n_bad = 0, ss_hi = 0, model_ch = 0;
  bit chk_en = 1'b0;

  // Pending output events: 0 = frame accepted, 1 = frame error, 2 = reset.
  typedef struct { int cyc; int kind; logic [15:0] w; } ev_t;
  ev_t evq[$];
  logic [15:0] exp_cmd  = 16'h0;
  logic [2:0]  exp_chnl = 3'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign ch_data[k*DATA_W +: DATA_W] = ch_arr[k];
  end

  a2d_spi_resp #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ch_data(ch_data), .cmd(cmd), .chnl(chnl), .cmd_rdy(cmd_rdy), .frame_err(frame_err));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) if (chk_en) begin : cmp
    bit exp_rdy, exp_err, rs;
    ev_t e;
    exp_rdy = 1'b0; exp_err = 1'b0; rs = 1'b0;
    while (evq.size() > 0 && evq[0].cyc <= cyc) begin
      e = evq.pop_front();
      case (e.kind)
        0: begin exp_cmd = e.w; exp_chnl = e.w[13:11]; exp_rdy = 1'b1; end
        1: exp_err = 1'b1;
        default: begin exp_cmd = 16'h0; exp_chnl = 3'h0; rs = 1'b1; end
      endcase
    end
    chk("cmd", cmd, exp_cmd);
    chk("chnl", chnl, exp_chnl);
    chk("cmd_rdy", cmd_rdy, exp_rdy);
    chk("frame_err", frame_err, exp_err);
    if (rs || ss_hi >= PH) chk("miso_idle", MISO, 1'b0);
    ss_hi = SS_n ? ss_hi + 1 : 0;
  end

  task automatic do_rst();
    rst = 1'b1;
    evq.push_back('{cyc + 1, 2, 16'h0});
    model_ch = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One master frame; rst_after/chg_after = 0 disables those disturbances.
  task automatic frame(input logic [15:0] mosi, input int nbits, input int ph,
                       input int rst_after, input int chg_after,
                       input logic [DATA_W-1:0] chg_val, output logic [15:0] got);
    logic [15:0] snap;
    bit aborted;
    snap = {4'h0, ch_arr[model_ch]};
    got = 16'h0;
    aborted = 1'b0;
    SS_n = 1'b0;
    repeat (ph) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = mosi[15-i];
      repeat (ph) @(negedge clk);
      got[15-i] = MISO;
      SCLK = 1'b1;
      repeat (ph) @(negedge clk);
      if (i + 1 == rst_after) begin do_rst(); aborted = 1'b1; end
      if (i + 1 == chg_after) ch_arr[model_ch] = chg_val;
    end
    SS_n = 1'b1;
    if (!aborted) begin
      if (nbits == 16) begin
        evq.push_back('{cyc + SYNC + 1, 0, mosi});
        model_ch = int'(mosi[13:11]);
      end else begin
        evq.push_back('{cyc + SYNC + 1, 1, 16'h0});
      end
    end
    repeat (ph + SYNC + 2) @(negedge clk);
    if (!aborted && nbits == 16) chk("miso_word_model", got, snap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] w;
    int prev;
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    for (int k = 0; k < NUM_CH; k++) ch_arr[k] = '0;
    ch_arr[0] = 12'hABC;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_chnl", chnl, 3'd0);
    chk("rst_miso", MISO, 1'b0);

    frame(16'h1800, 16, PH + 3, 0, 0, '0, w);
    chk("f1_miso", w, 16'h0ABC);
    chk("f1_cmd", cmd, 16'h1800);
    chk("f1_chnl", chnl, 3'd3);

    ch_arr[3] = 12'h5A5;
    frame(16'h1FFF, 16, PH, 0, 0, '0, w);
    chk("f2_miso", w, 16'h05A5);

    for (int k = 0; k < NUM_CH; k++) ch_arr[k] = 12'h100 + DATA_W'(k);
    prev = 3;
    for (int k = 0; k < NUM_CH; k++) begin
      frame({2'b00, 3'(k), 11'h0}, 16, PH, 0, 0, '0, w);
      chk("sweep_miso", w, 16'h0100 + 16'(prev));
      prev = k;
    end
    frame(16'h2000, 16, PH, 0, 0, '0, w);
    chk("sweep_last", w, 16'h0107);

    frame(16'hFFFF, 9, PH, 0, 0, '0, w);
    chk("short_cmd", cmd, 16'h2000);
    chk("short_chnl", chnl, 3'd4);
    frame(16'h1800, 16, PH, 0, 0, '0, w);
    chk("after_short", w, 16'h0104);

    frame(16'h3800, 16, PH, 5, 0, '0, w);
    chk("midrst_cmd", cmd, 16'h0000);
    chk("midrst_chnl", chnl, 3'd0);
    frame(16'h0000, 16, PH, 0, 0, '0, w);
    chk("after_rst", w, 16'h0100);

    ch_arr[0] = 12'h111;
    frame(16'h0000, 16, PH, 0, 4, 12'h222, w);
    chk("snapshot", w, 16'h0111);
    frame(16'h0000, 16, PH, 0, 0, '0, w);
    chk("post_change", w, 16'h0222);

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
